// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM states, MISR defaults and the MISR step
// function, also used by the LFSR pattern generator.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        CAPTURE,
        DONE
    } bist_state_e;

    localparam int unsigned DEF_SIG_W = 16;
    localparam logic [15:0] DEF_POLY  = 16'h1021;

    // Computed on 64-bit containers so callers of any width up to 64 can share it.
    function automatic logic [63:0] misr_step(
        input logic [63:0] sig,
        input logic [63:0] poly,
        input logic [63:0] data,
        input int unsigned width
    );
        logic [63:0] mask;
        logic [63:0] fb;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        fb   = (((sig >> (width - 1)) & 64'd1) != 64'd0) ? poly : 64'd0;
        return ((sig << 1) ^ fb ^ data) & mask;
    endfunction

endpackage

// File: rtl/bist_misr_reg.sv
// Signature register: synchronous clear, enable-gated MISR step.
// nxt_o exposes the value the next enabled step would load.
module bist_misr_reg
    import bist_pkg::*;
#(
    parameter int unsigned      SIG_W  = DEF_SIG_W,
    parameter int unsigned      RESP_W = 6,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY)
) (
    input  logic              CK,
    input  logic              RSTN,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [RESP_W-1:0] data_i,
    output logic [SIG_W-1:0]  sig_o,
    output logic [SIG_W-1:0]  nxt_o
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    assign nxt_o = SIG_W'(misr_step(64'(sig_q), 64'(POLY), 64'(data_i), SIG_W));

    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = nxt_o;
        end
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/bist_misr_compactor.sv
// BIST response compactor: flush window, MISR capture, golden compare.
// Define MISR_XMASK_EN to add the xmask port for masking unknown outputs.
module bist_misr_compactor
    import bist_pkg::*;
#(
    parameter int unsigned      RESP_W      = 6,
    parameter int unsigned      SIG_W       = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY        = SIG_W'(DEF_POLY),
    parameter int unsigned      FLUSH_LEN   = 4,
    parameter int unsigned      CAPTURE_LEN = 64,
    parameter logic [SIG_W-1:0] GOLDEN      = '0,
    parameter int unsigned      CNT_W       = 8
) (
    input  logic              CK,
    input  logic              RSTN,
    input  logic              start,
    input  logic [RESP_W-1:0] resp,
    input  logic              resp_valid,
`ifdef MISR_XMASK_EN
    input  logic [RESP_W-1:0] xmask,
`endif
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
    output logic              pass
);

    localparam logic [CNT_W-1:0] FL_LAST =
        CNT_W'((FLUSH_LEN == 0) ? 0 : FLUSH_LEN - 1);
    localparam logic [CNT_W-1:0] CL_LAST = CNT_W'(CAPTURE_LEN - 1);
    localparam bist_state_e FIRST = (FLUSH_LEN != 0) ? FLUSH : CAPTURE;

    bist_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic             clr, en;
    logic [RESP_W-1:0] data;
    logic [SIG_W-1:0] sig_nxt;

`ifdef MISR_XMASK_EN
    assign data = resp & ~xmask;
`else
    assign data = resp;
`endif

    bist_misr_reg #(
        .SIG_W (SIG_W),
        .RESP_W(RESP_W),
        .POLY  (POLY)
    ) u_misr (
        .CK    (CK),
        .RSTN  (RSTN),
        .clr_i (clr),
        .en_i  (en),
        .data_i(data),
        .sig_o (signature),
        .nxt_o (sig_nxt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        clr     = 1'b0;
        en      = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    clr     = 1'b1;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    state_d = FIRST;
                end
            end
            FLUSH: begin
                if (resp_valid) begin
                    if (cnt_q == FL_LAST) begin
                        cnt_d   = '0;
                        state_d = CAPTURE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (resp_valid) begin
                    en = 1'b1;
                    if (cnt_q == CL_LAST) begin
                        cnt_d   = '0;
                        pass_d  = (sig_nxt == GOLDEN);
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign busy = (state_q == FLUSH) || (state_q == CAPTURE);
    assign done = (state_q == DONE);
    assign pass = pass_q;

endmodule

// File: tb/tb_bist_misr_compactor.sv
// Bench for bist_misr_compactor: four configurations driven side by side,
// checked against a word-queue model of the flush/capture rules.
module tb_bist_misr_compactor;

    localparam int NI = 4;

    function automatic int fl_of(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    function automatic int cl_of(input int k);
        return (k == 0) ? 64 : (k == 1) ? 2 : (k == 2) ? 1 : 17;
    endfunction

    logic        CK;
    logic        RSTN;
    logic        start  [NI];
    logic [5:0]  resp_d [NI];
    logic        resp_v [NI];
    logic [5:0]  xm_d   [NI];
    logic        busy   [NI];
    logic        done   [NI];
    logic [15:0] sig    [NI];
    logic        pass   [NI];

    int ncmp;
    int nfail;

    initial CK = 1'b0;
    always #5 CK = ~CK;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bist_misr_compactor #(
            .FLUSH_LEN  (g == 0 ? 4 : 0),
            .CAPTURE_LEN(g == 0 ? 64 : g == 1 ? 2 : g == 2 ? 1 : 17)
        ) u_dut (
            .CK        (CK),
            .RSTN      (RSTN),
            .start     (start[g]),
            .resp      (resp_d[g]),
            .resp_valid(resp_v[g]),
`ifdef MISR_XMASK_EN
            .xmask     (xm_d[g]),
`endif
            .busy      (busy[g]),
            .done      (done[g]),
            .signature (sig[g]),
            .pass      (pass[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a run is the sequence of accepted words; the first
    // FLUSH_LEN are dropped, the next CAPTURE_LEN are folded into the
    // signature by polynomial division over GF(2) (multiply by x, reduce).
    function automatic int model_sig(input int q[$], input int fl,
                                     input int cl, input int xm);
        int s;
        s = 0;
        for (int i = fl; i < fl + cl; i++) begin
            int d;
`ifdef MISR_XMASK_EN
            d = q[i] & ~xm & 63;
`else
            d = q[i] + 0 * xm;
`endif
            s = ((s * 2) % 65536) ^ ((s >= 32768) ? 'h1021 : 0) ^ d;
        end
        return s;
    endfunction

    task automatic do_run(input int k, input bit stall, input bit rnd,
                          input logic [5:0] fval, input logic [5:0] hit,
                          input bit dbl, input logic [5:0] xm,
                          output logic [15:0] msig);
        int fl, cl, need, nv, ns, cyc, exp_cyc, got_cyc, s;
        int q[$];
        bit vld;
        logic [5:0] w;
        fl = fl_of(k);
        cl = cl_of(k);
        need = fl + cl;
        nv = 0;
        ns = 0;
        exp_cyc = 0;
        start[k] = 1'b1;
        @(negedge CK);
        start[k] = 1'b0;
        cyc = 1;
        chk("busy_after_start", 32'(busy[k]), 32'd1);
        chk("done_dropped", 32'(done[k]), 32'd0);
        chk("pass_dropped", 32'(pass[k]), 32'd0);
        while (!done[k] && cyc < 400) begin
            vld = (nv < need) && !(stall && (cyc % 2 == 0));
            if (nv < need && !vld) ns++;
            if (vld) begin
                if (rnd) w = 6'($urandom_range(0, 63));
                else if (nv < fl) w = fval;
                else if (nv == fl) w = hit;
                else w = 6'h00;
                q.push_back(int'(w));
                nv++;
                if (nv == need) exp_cyc = cyc + 1;
            end else begin
                w = 6'($urandom_range(0, 63));
            end
            resp_v[k] = vld;
            resp_d[k] = w;
            xm_d[k]   = xm;
            start[k]  = dbl && (cyc == 3);
            @(negedge CK);
            cyc++;
        end
        resp_v[k] = 1'b0;
        start[k]  = 1'b0;
        got_cyc = done[k] ? cyc : -1;
        chk("done_cycle", 32'(got_cyc), 32'(exp_cyc));
        chk("done_latency", 32'(got_cyc), 32'(need + 1 + ns));
        s = model_sig(q, fl, cl, int'(xm));
        msig = 16'(s);
        chk("signature", 32'(sig[k]), 32'(msig));
        chk("pass", 32'(pass[k]), 32'(msig == 16'h0000));
        chk("busy_at_done", 32'(busy[k]), 32'd0);
        @(negedge CK);
        chk("sig_held", 32'(sig[k]), 32'(msig));
        chk("done_held", 32'(done[k]), 32'd1);
    endtask

    initial begin
        logic [15:0] m, m2;
        ncmp  = 0;
        nfail = 0;
        RSTN  = 1'b0;
        for (int i = 0; i < NI; i++) begin
            start[i]  = 1'b0;
            resp_d[i] = '0;
            resp_v[i] = 1'b0;
            xm_d[i]   = '0;
        end
        repeat (2) @(negedge CK);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_done", 32'(done[0]), 32'd0);
        chk("rst_sig", 32'(sig[0]), 32'd0);
        chk("rst_pass", 32'(pass[0]), 32'd0);
        RSTN = 1'b1;
        @(negedge CK);

        // Reset arriving mid-capture, between clock edges.
        start[0] = 1'b1;
        @(negedge CK);
        start[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            resp_v[0] = 1'b1;
            resp_d[0] = 6'h3F;
            @(negedge CK);
        end
        resp_v[0] = 1'b0;
        chk("midrun_busy", 32'(busy[0]), 32'd1);
        #2 RSTN = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy[0]), 32'd0);
        chk("async_rst_sig", 32'(sig[0]), 32'd0);
        @(negedge CK);
        RSTN = 1'b1;
        @(negedge CK);

        do_run(0, 1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 6'h00, m);
        chk("zero_run_sig", 32'(sig[0]), 32'h0000);
        chk("zero_run_pass", 32'(pass[0]), 32'd1);

        do_run(1, 1'b0, 1'b0, 6'h00, 6'h01, 1'b0, 6'h00, m);
        chk("hit_cl2", 32'(sig[1]), 32'h0002);
        do_run(2, 1'b0, 1'b0, 6'h00, 6'h01, 1'b0, 6'h00, m);
        chk("hit_cl1", 32'(sig[2]), 32'h0001);
        do_run(3, 1'b0, 1'b0, 6'h00, 6'h01, 1'b0, 6'h00, m);
        chk("wrap_sig", 32'(sig[3]), 32'h1021);
        chk("wrap_pass", 32'(pass[3]), 32'd0);

        do_run(0, 1'b1, 1'b0, 6'h3F, 6'h00, 1'b0, 6'h00, m);
        chk("flush_stall_sig", 32'(sig[0]), 32'h0000);

        do_run(1, 1'b0, 1'b0, 6'h00, 6'h2A, 1'b0, 6'h00, m);
        do_run(1, 1'b0, 1'b0, 6'h00, 6'h2A, 1'b0, 6'h00, m2);
        chk("restart_same_sig", 32'(sig[1]), 32'(m));

        do_run(0, 1'b0, 1'b1, 6'h00, 6'h00, 1'b1, 6'h00, m);
        do_run(0, 1'b1, 1'b1, 6'h00, 6'h00, 1'b0, 6'h00, m);
        do_run(3, 1'b1, 1'b1, 6'h00, 6'h00, 1'b1, 6'h00, m);
        do_run(3, 1'b0, 1'b1, 6'h00, 6'h00, 1'b0, 6'h00, m);

`ifdef MISR_XMASK_EN
        do_run(1, 1'b0, 1'b0, 6'h00, 6'h01, 1'b0, 6'h01, m);
        chk("xmask_hit", 32'(sig[1]), 32'h0000);
        do_run(3, 1'b0, 1'b1, 6'h00, 6'h00, 1'b0, 6'h15, m);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
